// File: rtl/jtframe_dual_ram_clr.sv
// Dual-port byte-writable RAM with a built-in clear engine.
// Both ports share one clock. Each port has a clock enable, byte-lane write
// enables and a registered read output with one cycle of latency. The clear
// engine sweeps FILL into every word after reset or on request. While the
// sweep runs it owns the memory: user writes are dropped and enabled reads
// return FILL.
module jtframe_dual_ram_clr #(
  parameter int              DW   = 16,
  parameter int              AW   = 10,
  parameter logic [DW-1:0]   FILL = {DW{1'b0}},
  parameter int              RDW  = 0
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              cen0,
  input  logic [AW-1:0]     addr0,
  input  logic [DW-1:0]     data0,
  input  logic [DW/8-1:0]   we0,
  output logic [DW-1:0]     q0,
  // port 1
  input  logic              cen1,
  input  logic [AW-1:0]     addr1,
  input  logic [DW-1:0]     data1,
  input  logic [DW/8-1:0]   we1,
  output logic [DW-1:0]     q1,
  // clear engine
  input  logic              clr,
  output logic              busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_busy;
  logic [DW-1:0]   r_q0;
  logic [DW-1:0]   r_q1;

  // NOTE: the storage array has no reset; a reset loop over every word would
  // stop it mapping onto block RAM. The clear engine provides known contents.
  logic [DW-1:0]   r_mem [DEPTH];

  logic [DW-1:0]   w_old0;
  logic [DW-1:0]   w_old1;
  logic [DW-1:0]   w_merged0;
  logic [DW-1:0]   w_merged1;
  logic            w_user_wr;
  logic            w_cnt_last;

  // Overlay the enabled byte lanes of new_w onto old_w.
  function automatic logic [DW-1:0] f_merge(
    input logic [DW-1:0] old_w,
    input logic [DW-1:0] new_w,
    input logic [NB-1:0] lane_we
  );
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_old0     = r_mem[addr0];
  assign w_old1     = r_mem[addr1];
  assign w_merged0  = f_merge(w_old0, data0, we0);
  assign w_merged1  = f_merge(w_old1, data1, we1);
  // Users may only touch the array while the clear engine is idle.
  assign w_user_wr  = !rst && !r_busy;
  assign w_cnt_last = (r_cnt == {AW{1'b1}});

  // Clear engine: two-state sweep with a registered busy flag.
  // Reset lands in CLEAR so the first cycle out of reset starts the sweep.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every always_ff sees the values from before the current edge.
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clr is ignored here; the sweep always runs to the last word.
          r_cnt <= r_cnt + {{(AW-1){1'b0}}, 1'b1};
          if (w_cnt_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Memory array writes: the sweep word, or user byte lanes when idle.
  // Port 1 lanes are assigned after port 0 lanes, so a lane enabled on both
  // ports for the same address takes port 1's data.
  always_ff @(posedge clk) begin
    if (!rst && r_busy) begin
      r_mem[r_cnt] <= FILL;
    end else if (w_user_wr) begin
      if (cen0) begin
        for (int i = 0; i < NB; i++) begin
          if (we0[i]) r_mem[addr0][8*i +: 8] <= data0[8*i +: 8];
        end
      end
      if (cen1) begin
        for (int i = 0; i < NB; i++) begin
          if (we1[i]) r_mem[addr1][8*i +: 8] <= data1[8*i +: 8];
        end
      end
    end
  end

  // Port 0 read register: FILL while the sweep runs, otherwise the stored
  // word, or the merged word when new-data read-during-write is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q0 <= '0;
    end else if (cen0) begin
      if (r_busy)        r_q0 <= FILL;
      else if (RDW != 0) r_q0 <= w_merged0;
      else               r_q0 <= w_old0;
    end
  end

  // Port 1 read register, same behaviour as port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
    end else if (cen1) begin
      if (r_busy)        r_q1 <= FILL;
      else if (RDW != 0) r_q1 <= w_merged1;
      else               r_q1 <= w_old1;
    end
  end

  assign q0   = r_q0;
  assign q1   = r_q1;
  assign busy = r_busy;

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Bench for jtframe_dual_ram_clr. Two instances share all inputs, one with
// old-data and one with new-data read-during-write. Stimulus computes the
// expected outputs from a word-array model and queues them; a monitor pops
// and compares them after each clock edge.
module tb_jtframe_dual_ram_clr;

  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] FILL  = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        clr   = 1'b0;
  logic        cen0  = 1'b0;
  logic        cen1  = 1'b0;
  logic [3:0]  addr0 = '0;
  logic [3:0]  addr1 = '0;
  logic [15:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic [1:0]  we0   = '0;
  logic [1:0]  we1   = '0;

  logic [15:0] q0_a, q1_a, q0_b, q1_b;
  logic        busy_a, busy_b;

  jtframe_dual_ram_clr #(.DW(16), .AW(AW), .FILL(FILL), .RDW(0)) dut_a (
    .clk(clk), .rst(rst),
    .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0_a),
    .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1_a),
    .clr(clr), .busy(busy_a)
  );

  jtframe_dual_ram_clr #(.DW(16), .AW(AW), .FILL(FILL), .RDW(1)) dut_b (
    .clk(clk), .rst(rst),
    .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0_b),
    .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1_b),
    .clr(clr), .busy(busy_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   passed  = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic string kind_name(input int k);
    case (k)
      0: return "q0_rdw0";
      1: return "q1_rdw0";
      2: return "q0_rdw1";
      3: return "q1_rdw1";
      4: return "busy_rdw0";
      default: return "busy_rdw1";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int k);
    case (k)
      0: return q0_a;
      1: return q1_a;
      2: return q0_b;
      3: return q1_b;
      4: return {15'd0, busy_a};
      default: return {15'd0, busy_b};
    endcase
  endfunction

  task automatic check(input string name, input int cyc, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
  endtask

  // Monitor: after each edge, compare every expectation due by now.
  always @(posedge clk) begin
    exp_t e;
    #2;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      check(kind_name(e.kind), e.cyc, actual(e.kind), e.exp);
    end
  end

  // ---------------- reference model ----------------
  // Memory as a plain word array; the clear sweep as "clearing" plus the next
  // word to fill. Read outputs are held between enabled reads.
  logic [15:0] m_mem [DEPTH];
  logic        m_clearing = 1'b1;
  int          m_pos      = 0;
  logic [15:0] e_q0a = '0, e_q1a = '0, e_q0b = '0, e_q1b = '0;

  function automatic logic [15:0] merge(input logic [15:0] old_w,
                                        input logic [15:0] new_w,
                                        input logic [1:0]  lanes);
    logic [15:0] r;
    r = old_w;
    if (lanes[0]) r[7:0]  = new_w[7:0];
    if (lanes[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  // Apply one cycle of inputs at the falling edge, advance the model and queue
  // the outputs expected after the following rising edge.
  task automatic drive(input logic r, input logic c,
                       input logic ce0, input logic [3:0] a0,
                       input logic [15:0] d0, input logic [1:0] w0,
                       input logic ce1, input logic [3:0] a1,
                       input logic [15:0] d1, input logic [1:0] w1);
    logic [15:0] old0, old1;
    int          tag;
    @(negedge clk);
    rst = r; clr = c;
    cen0 = ce0; addr0 = a0; data0 = d0; we0 = w0;
    cen1 = ce1; addr1 = a1; data1 = d1; we1 = w1;
    tag = cyc_cnt + 1;
    if (r) begin
      e_q0a = '0; e_q1a = '0; e_q0b = '0; e_q1b = '0;
      m_clearing = 1'b1;
      m_pos      = 0;
    end else if (m_clearing) begin
      if (ce0) begin e_q0a = FILL; e_q0b = FILL; end
      if (ce1) begin e_q1a = FILL; e_q1b = FILL; end
      m_mem[m_pos] = FILL;
      m_pos++;
      if (m_pos == DEPTH) m_clearing = 1'b0;
    end else begin
      old0 = m_mem[a0];
      old1 = m_mem[a1];
      if (ce0) begin e_q0a = old0; e_q0b = merge(old0, d0, w0); end
      if (ce1) begin e_q1a = old1; e_q1b = merge(old1, d1, w1); end
      if (ce0) m_mem[a0] = merge(m_mem[a0], d0, w0);
      if (ce1) m_mem[a1] = merge(m_mem[a1], d1, w1);
      if (c) begin m_clearing = 1'b1; m_pos = 0; end
    end
    sb.push_back('{tag, 0, e_q0a});
    sb.push_back('{tag, 1, e_q1a});
    sb.push_back('{tag, 2, e_q0b});
    sb.push_back('{tag, 3, e_q1b});
    sb.push_back('{tag, 4, {15'd0, m_clearing}});
    sb.push_back('{tag, 5, {15'd0, m_clearing}});
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    drive(1'b0, 1'b0, 1'b1, a0, 16'h0, 2'b00, 1'b1, a1, 16'h0, 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for a few cycles with reads requested: outputs stay zero.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b1, 4'(i), 16'h0, 2'b11, 1'b1, 4'(i), 16'h0, 2'b11);
    // Sweep after reset: busy for 16 cycles, reads return FILL meanwhile.
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));
    rd(4'd0, 4'd1);
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));

    // Byte-lane write on port 0, readback on port 1.
    drive(1'b0, 1'b0, 1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 16'h0, 2'b00);
    rd(4'd0, 4'd3);

    // Same-port read during write: old data vs merged data.
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0000, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00);
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00);
    rd(4'd5, 4'd5);

    // Cross-port read of a word being written returns the old word.
    drive(1'b0, 1'b0, 1'b1, 4'd5, 16'h0F0F, 2'b11, 1'b1, 4'd5, 16'h0, 2'b00);
    rd(4'd5, 4'd5);

    // Both ports write addr 7: shared lane goes to port 1.
    drive(1'b0, 1'b0, 1'b1, 4'd7, 16'h1111, 2'b11, 1'b1, 4'd7, 16'h2222, 2'b10);
    rd(4'd7, 4'd7);

    // clr accepted together with a write, re-pulsed 5 cycles later, and a
    // write attempted during the sweep.
    drive(1'b0, 1'b1, 1'b1, 4'd9, 16'h5A5A, 2'b11, 1'b1, 4'd9, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) rd(4'd9, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 4'd2, 16'hDEAD, 2'b11, 1'b1, 4'd2, 16'hC0DE, 2'b11);
    for (int i = 0; i < 14; i++) rd(4'd2, 4'd9);
    rd(4'd2, 4'd9);
    rd(4'd9, 4'd2);

    // Reset in the middle of a sweep restarts it from the first word.
    drive(1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 2'b00);
    idle(9);
    drive(1'b1, 1'b0, 1'b1, 4'd1, 16'h0, 2'b00, 1'b1, 4'd1, 16'h0, 2'b00);
    for (int i = 0; i < 17; i++) rd(4'(i % 16), 4'(i % 16));

    // Random traffic with occasional clear requests and resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom));
    end
    idle(20);
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(i));

    @(posedge clk);
    #4;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_dual_ram_clr.md
JTFRAME_DUAL_RAM_CLR -- requirements
Module: jtframe_dual_ram_clr

Interface
REQ-001 Parameter DW, 16: data width in bits; SHALL be a multiple of 8, with NB = DW/8 byte lanes.
REQ-002 Parameter AW, 10: address width; depth = 2**AW words.
REQ-003 Parameter FILL, {DW{1'b0}}: value written to every word by the clear engine.
REQ-004 Parameter RDW, 0: same-port read-during-write mode; 0 = old data, 1 = new (merged) data.
REQ-005 clk  in  1  single clock for both ports and the clear engine.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cen0  in  1  port 0 clock enable.
REQ-008 addr0  in  AW  port 0 address.
REQ-009 data0  in  DW  port 0 write data.
REQ-010 we0  in  NB  port 0 byte write enables; bit i covers data0[8i+7:8i].
REQ-011 q0  out  DW  port 0 registered read data.
REQ-012 cen1, addr1, data1, we1, q1: port 1, same widths and meanings as port 0.
REQ-013 clr  in  1  clear request, sampled every cycle.
REQ-014 busy  out  1  registered; high while the clear engine owns the memory.

Function
REQ-015 Read latency SHALL be 1 cycle: when cenN=1 at edge k, qN holds the result from edge k onward; when cenN=0, qN holds its value.
REQ-016 A write SHALL occur only when cenN=1, busy=0, and the we bit is set; only the enabled byte lanes change.
REQ-017 With RDW=0, a write-cycle read on the same port SHALL return the pre-write word; with RDW=1 it SHALL return the word after byte-lane merging.
REQ-018 Port 1 reading an address that port 0 writes in the same cycle SHALL return the old word, and the reverse case likewise, regardless of RDW.
REQ-019 If both ports write the same address in the same cycle, each byte lane enabled on both ports SHALL take port 1's data; lanes enabled on one port only take that port's data.
REQ-020 The clear engine SHALL be an FSM with states IDLE and CLEAR plus an AW-bit counter cnt.
REQ-021 In CLEAR, each cycle SHALL write FILL to mem[cnt] and increment cnt, independent of cen0 and cen1.
REQ-022 CLEAR SHALL go to IDLE after writing address 2**AW-1: exactly 2**AW write cycles, with cnt wrapping to 0.
REQ-023 busy SHALL be 1 in every cycle the FSM is in CLEAR and SHALL drop on the edge that enters IDLE.
REQ-024 clr=1 in IDLE SHALL enter CLEAR on the next edge with cnt=0; clr in CLEAR SHALL be ignored and not restart the sweep.
REQ-025 While busy=1, user writes on both ports SHALL be discarded, and a read with cenN=1 SHALL load FILL into qN.
REQ-026 A user write in the same cycle that clr is accepted in IDLE SHALL complete, then be overwritten by the sweep.

Reset
REQ-027 While rst=1: q0=0, q1=0, busy=1, state=CLEAR, cnt=0; no memory writes.
REQ-028 The sweep SHALL start on the first edge with rst=0, so busy falls 2**AW cycles after rst deasserts.
REQ-029 rst asserted mid-sweep SHALL restart the sweep from cnt=0.
REQ-030 Memory contents SHALL NOT be otherwise initialised; after reset, memory equals FILL everywhere.

Verification
REQ-031 AW=4, FILL=16'hA5A5: release rst, count cycles -> busy high exactly 16 cycles; reads of all 16 addresses return A5A5.
REQ-032 After clear, port 0 writes 16'h1234 to addr 3 with we0=2'b01 -> port 1 reads 16'hA534 one cycle later.
REQ-033 RDW=0 vs RDW=1: write 16'hBEEF to addr 5 (previously 0) with a same-port read in the same cycle -> q0=0000 (RDW=0), q0=BEEF (RDW=1).
REQ-034 Both ports write addr 7 in the same cycle: port 0 writes 1111 with we=11, port 1 writes 2222 with we=10 -> addr 7 reads 2211.
REQ-035 Pulse clr, then pulse clr again 5 cycles later, and attempt a write during busy -> busy lasts 16 cycles, the write is lost, and q reads FILL during busy.
REQ-036 Assert rst for 1 cycle at cnt=9 -> sweep restarts at cnt=0, and busy stays high 16 more cycles.
